// File: rtl/countdown_ctrl_if.sv
// Control/status bundle between the game FSM, the 1 s tick generator and countdown_ctrl.
// master drives commands and the tick; slave is the countdown controller itself.
interface countdown_ctrl_if;
    logic       start;
    logic       pause;
    logic       abort;
    logic [6:0] load_secs;
    logic       tick;
    logic       tick_en;
    logic [6:0] secs_left;
    logic [3:0] secs_tens;
    logic [3:0] secs_ones;
    logic       running;
    logic       paused;
    logic       expired;
    logic       done;

    modport master (
        output start, pause, abort, load_secs, tick,
        input  tick_en, secs_left, secs_tens, secs_ones, running, paused, expired, done
    );

    modport slave (
        input  start, pause, abort, load_secs, tick,
        output tick_en, secs_left, secs_tens, secs_ones, running, paused, expired, done
    );
endinterface

// File: rtl/countdown_ctrl.sv
// Seconds countdown sequencer: loads a count, gates the 1 s tick generator and
// counts down to expiry, with pause/resume, restart and abort. All outputs registered.
module countdown_ctrl #(
    parameter int MAX_SECS = 99
) (
    input  logic              clk,
    input  logic              rst_n,
    countdown_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUNNING,
        PAUSED,
        EXPIRED
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [6:0] count_nx;
    logic [6:0] load_clamped;
    logic       done_nx;

    function automatic logic [6:0] clamp_secs(input logic [6:0] v);
        if (v > 7'(MAX_SECS)) begin
            return 7'(MAX_SECS);
        end
        return v;
    endfunction

    function automatic logic [3:0] bcd_tens(input logic [6:0] v);
        return 4'(v / 7'd10);
    endfunction

    function automatic logic [3:0] bcd_ones(input logic [6:0] v);
        return 4'(v % 7'd10);
    endfunction

    assign load_clamped = clamp_secs(bus.load_secs);

    // Next-state / next-count: abort > start > pause > tick
    always_comb begin
        state_nx = state;
        count_nx = bus.secs_left;
        done_nx  = 1'b0;

        if (bus.abort) begin
            state_nx = IDLE;
            count_nx = '0;
        end else if (bus.start) begin
            count_nx = load_clamped;
            if (load_clamped == '0) begin
                state_nx = EXPIRED;
                done_nx  = 1'b1;
            end else begin
                state_nx = ARM;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    state_nx = IDLE;
                end
                // One dead cycle with tick_en low so the tick generator restarts a full interval.
                ARM: begin
                    state_nx = RUNNING;
                end
                RUNNING: begin
                    if (bus.pause) begin
                        state_nx = PAUSED;
                    end else if (bus.tick) begin
                        if (bus.secs_left > 7'd1) begin
                            count_nx = bus.secs_left - 7'd1;
                        end else begin
                            count_nx = '0;
                            state_nx = EXPIRED;
                            done_nx  = 1'b1;
                        end
                    end
                end
                PAUSED: begin
                    if (bus.pause) begin
                        state_nx = RUNNING;
                    end
                end
                EXPIRED: begin
                    count_nx = '0;
                end
                default: begin
                    state_nx = IDLE;
                    count_nx = '0;
                end
            endcase
        end
    end

    // Registered state, count and decoded outputs (decode uses next state so outputs align with it)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.secs_left <= '0;
            bus.secs_tens <= '0;
            bus.secs_ones <= '0;
            bus.tick_en   <= 1'b0;
            bus.running   <= 1'b0;
            bus.paused    <= 1'b0;
            bus.expired   <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            state         <= state_nx;
            bus.secs_left <= count_nx;
            bus.secs_tens <= bcd_tens(count_nx);
            bus.secs_ones <= bcd_ones(count_nx);
            bus.tick_en   <= (state_nx == RUNNING);
            bus.running   <= (state_nx == RUNNING);
            bus.paused    <= (state_nx == PAUSED);
            bus.expired   <= (state_nx == EXPIRED);
            bus.done      <= done_nx;
        end
    end

endmodule
